reveal_controller: RTL and testbench

RECOVERY_REVEAL is not a name I want; final below.

---
 rtl/reveal_controller.sv | 127 ++++++++++++
 tb/tb_reveal_controller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reveal_controller.sv
// Flood-fill reveal engine for an 8x8 mine board: one tile revealed per cycle,
// with zero-count tiles queueing their hidden, unmined neighbours in a pending bitmap.
module reveal_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        start,
    input  logic [5:0]  start_index,
    input  logic [63:0] mine_map,
    input  logic [3:0]  nb_count,
    output logic [5:0]  nb_index,
    output logic [63:0] revealed,
    output logic [6:0]  revealed_count,
    output logic        busy,
    output logic        done,
    output logic        hit_mine
);

    // start is a single-cycle request taken only in IDLE; any start seen while
    // busy is dropped. done pulses once per accepted start, never for an abort.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VISIT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [63:0] COL0 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] COL7 = 64'h8080_8080_8080_8080;

    state_t      state;
    state_t      state_next;
    logic [63:0] pending;
    logic [63:0] pending_next;
    logic [63:0] revealed_next;
    logic [6:0]  count_next;
    logic        hit_next;
    logic [63:0] p_onehot;
    logic [63:0] start_onehot;
    logic [63:0] nbr_mask;

    always_comb begin
        nb_index = '0;
        if (state == VISIT) begin
            for (int i = 63; i >= 0; i--) begin
                if (pending[i]) nb_index = 6'(i);
            end
        end
    end

    assign p_onehot     = 64'd1 << nb_index;
    assign start_onehot = 64'd1 << start_index;

    // Horizontal shifts that land in the opposite edge column are row wrap-arounds.
    assign nbr_mask = (p_onehot << 8) | (p_onehot >> 8)
                    | (((p_onehot << 1) | (p_onehot << 9) | (p_onehot >> 7)) & ~COL0)
                    | (((p_onehot >> 1) | (p_onehot >> 9) | (p_onehot << 7)) & ~COL7);

    always_comb begin
        state_next    = state;
        pending_next  = pending;
        revealed_next = revealed;
        count_next    = revealed_count;
        hit_next      = hit_mine;
        case (state)
            IDLE: begin
                if (start && !hit_mine) begin
                    if (revealed[start_index]) begin
                        state_next = DONE;
                    end else if (mine_map[start_index]) begin
                        revealed_next = revealed | start_onehot;
                        count_next    = revealed_count + 7'd1;
                        hit_next      = 1'b1;
                        state_next    = DONE;
                    end else begin
                        pending_next = start_onehot;
                        state_next   = VISIT;
                    end
                end
            end
            VISIT: begin
                if (pending == '0) begin
                    state_next = DONE;
                end else begin
                    revealed_next = revealed | p_onehot;
                    count_next    = revealed_count + 7'd1;
                    pending_next  = pending & ~p_onehot;
                    if (nb_count == 4'd0) begin
                        pending_next = pending_next | (nbr_mask & ~revealed & ~mine_map);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clear) begin
            state_next    = IDLE;
            pending_next  = '0;
            revealed_next = '0;
            count_next    = '0;
            hit_next      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pending        <= '0;
            revealed       <= '0;
            revealed_count <= '0;
            hit_mine       <= 1'b0;
        end else begin
            state          <= state_next;
            pending        <= pending_next;
            revealed       <= revealed_next;
            revealed_count <= count_next;
            hit_mine       <= hit_next;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_reveal_controller.sv
// Bench for reveal_controller: neighbour-counter model, flood-fill reference,
// directed vector table, hand sequences for abort/ignore cases, random boards.
module tb_reveal_controller;

    localparam int W = 81;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        start;
    logic [5:0]  start_index;
    logic [63:0] mine_map;
    logic [3:0]  nb_count;
    logic [5:0]  nb_index;
    logic [63:0] revealed;
    logic [6:0]  revealed_count;
    logic        busy;
    logic        done;
    logic        hit_mine;

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [63:0]  m_rev;
    logic         m_hit;

    typedef struct {
        logic        do_clear;
        logic [63:0] mine;
        logic [5:0]  idx;
        logic        exp_done;
        logic [63:0] exp_rev;
        logic [6:0]  exp_cnt;
        logic        exp_hit;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    reveal_controller dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .start          (start),
        .start_index    (start_index),
        .mine_map       (mine_map),
        .nb_count       (nb_count),
        .nb_index       (nb_index),
        .revealed       (revealed),
        .revealed_count (revealed_count),
        .busy           (busy),
        .done           (done),
        .hit_mine       (hit_mine)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] count_mines(input logic [63:0] mm, input logic [5:0] t);
        int r;
        int c;
        int n;
        n = 0;
        r = int'(t) / 8;
        c = int'(t) % 8;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 &&
                    c + dc >= 0 && c + dc < 8) begin
                    if (mm[(r + dr) * 8 + c + dc]) n++;
                end
            end
        end
        return 4'(n);
    endfunction

    assign nb_count = count_mines(mine_map, nb_index);

    task automatic model_start(input logic [63:0] mine, input logic [5:0] s,
                               input logic [63:0] rev_in, output logic [63:0] rev_out,
                               output int n, output logic mine_hit);
        logic [63:0] fill;
        bit changed;
        int r;
        int c;
        int q;
        rev_out  = rev_in;
        n        = 0;
        mine_hit = 1'b0;
        if (rev_in[s]) return;
        if (mine[s]) begin
            rev_out[s] = 1'b1;
            n = 1;
            mine_hit = 1'b1;
            return;
        end
        fill = '0;
        fill[s] = 1'b1;
        do begin
            changed = 1'b0;
            for (int t = 0; t < 64; t++) begin
                if (fill[t] && count_mines(mine, 6'(t)) == 4'd0) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            r = t / 8 + dr;
                            c = t % 8 + dc;
                            if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && c >= 0 && c < 8) begin
                                q = r * 8 + c;
                                if (!mine[q] && !rev_in[q] && !fill[q]) begin
                                    fill[q] = 1'b1;
                                    changed = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end while (changed);
        rev_out = rev_in | fill;
        n = $countones(fill);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic ed, input logic [63:0] rev, input logic [6:0] cnt,
                            input logic hit, input int lat);
        exp_q.push_back({ed, rev, cnt, hit, 8'(lat)});
    endtask

    task automatic predict_push(input logic [5:0] idx);
        logic [63:0] nrev;
        int n;
        logic h;
        if (m_hit) begin
            push_exp(1'b0, m_rev, 7'($countones(m_rev)), 1'b1, 0);
        end else begin
            model_start(mine_map, idx, m_rev, nrev, n, h);
            push_exp(1'b1, nrev, 7'($countones(nrev)), h, (h || m_rev[idx]) ? 0 : n + 1);
            m_rev = nrev;
            m_hit = h;
        end
    endtask

    task automatic wait_check(input int lat0);
        logic [W-1:0] e;
        int lat;
        int bound;
        logic got;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = exp_q.pop_front();
        bound = e[80] ? 200 : 8;
        lat = lat0;
        got = 1'b0;
        while (lat < bound) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check("done_seen", 64'(got), 64'(e[80]));
        if (got && e[80]) check("latency", 64'(lat), 64'(e[7:0]));
        if (got) begin
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
        end
        check("busy_after", 64'(busy), 64'd0);
        check("revealed", revealed, e[79:16]);
        check("revealed_count", 64'(revealed_count), 64'(e[15:9]));
        check("hit_mine", 64'(hit_mine), 64'(e[8]));
    endtask

    task automatic do_start(input logic [5:0] idx);
        start = 1'b1;
        start_index = idx;
        @(negedge clk);
        start = 1'b0;
        wait_check(0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_rev = '0;
        m_hit = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_revealed"}, revealed, 64'd0);
        check({tag, "_count"}, 64'(revealed_count), 64'd0);
        check({tag, "_hit"}, 64'(hit_mine), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_nb_index"}, 64'(nb_index), 64'd0);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 64'h0,              6'd0,  1'b1, ~64'h0,              7'd64, 1'b0, 65};
        vecs[1] = '{1'b1, 64'h200,            6'd0,  1'b1, 64'h1,               7'd1,  1'b0, 2};
        vecs[2] = '{1'b1, 64'h200,            6'd63, 1'b1, ~64'h303,            7'd60, 1'b0, 61};
        vecs[3] = '{1'b0, 64'h200,            6'd0,  1'b1, ~64'h302,            7'd61, 1'b0, 2};
        vecs[4] = '{1'b0, 64'h200,            6'd5,  1'b1, ~64'h302,            7'd61, 1'b0, 0};
        vecs[5] = '{1'b1, 64'h800_0000,       6'd27, 1'b1, 64'h800_0000,        7'd1,  1'b1, 0};
        vecs[6] = '{1'b0, 64'h800_0000,       6'd0,  1'b0, 64'h800_0000,        7'd1,  1'b1, 0};
        vecs[7] = '{1'b1, 64'h1010101010101010, 6'd0, 1'b1, 64'h0F0F0F0F0F0F0F0F, 7'd32, 1'b0, 33};

        rst = 1'b1;
        clear = 1'b0;
        start = 1'b0;
        start_index = '0;
        mine_map = '0;
        m_rev = '0;
        m_hit = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors; boards carry over where do_clear is 0.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_clear) pulse_clear();
            mine_map = vecs[i].mine;
            push_exp(vecs[i].exp_done, vecs[i].exp_rev, vecs[i].exp_cnt,
                     vecs[i].exp_hit, vecs[i].exp_lat);
            do_start(vecs[i].idx);
            m_rev = vecs[i].exp_rev;
            m_hit = vecs[i].exp_hit;
        end

        // Start pulse while busy must be dropped; also probe nb_index early in the flood.
        pulse_clear();
        mine_map = '0;
        push_exp(1'b1, ~64'h0, 7'd64, 1'b0, 65);
        start = 1'b1;
        start_index = 6'd0;
        @(negedge clk);
        start = 1'b0;
        check("busy_in_visit", 64'(busy), 64'd1);
        check("nb_index_first", 64'(nb_index), 64'd0);
        @(negedge clk);
        check("nb_index_second", 64'(nb_index), 64'd1);
        check("count_mid_flood", 64'(revealed_count), 64'd1);
        start = 1'b1;
        start_index = 6'd40;
        @(negedge clk);
        start = 1'b0;
        wait_check(2);
        watch_no_done("no_extra_done", 5);

        // clear wins over a simultaneous start.
        clear = 1'b1;
        start = 1'b1;
        start_index = 6'd0;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check_all_zero("clear_vs_start");
        watch_no_done("clear_vs_start_no_done", 3);

        // clear mid-flood aborts with no done.
        start = 1'b1;
        start_index = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_all_zero("clear_mid_visit");
        watch_no_done("clear_abort_no_done", 70);

        // reset mid-flood, then the next start sees an empty board.
        start = 1'b1;
        start_index = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset_mid_visit");
        watch_no_done("reset_abort_no_done", 3);
        mine_map = 64'h200;
        m_rev = '0;
        m_hit = 1'b0;
        push_exp(1'b1, 64'h1, 7'd1, 1'b0, 2);
        do_start(6'd0);

        // Random sparse boards against the reference flood fill.
        for (int r = 0; r < 6; r++) begin
            logic [5:0] idx;
            pulse_clear();
            mine_map = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            for (int k = 0; k < 2; k++) begin
                idx = 6'($urandom_range(0, 63));
                predict_push(idx);
                do_start(idx);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
